// File: rtl/wb_retire_arbiter_pkg.sv
// Shared opcode/aluop encodings, architectural register numbers and the writeback
// decode used by the retire arbiter.
package wb_retire_arbiter_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0] R_RA     = 5'd31;
  localparam logic [4:0] R_STATUS = 5'd30;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_SETX = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic    we;
    logic [4:0] rd;
    wb_src_e src;
  } wb_dec_t;

  // mul/div leave the pipeline without a write; their result arrives later via the queue.
  function automatic wb_dec_t wb_decode(input logic [31:0] ir);
    wb_dec_t d;
    d.we  = 1'b0;
    d.rd  = ir[26:22];
    d.src = SRC_ALU;
    case (ir[31:27])
      OP_RTYPE: d.we = !((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
      OP_ADDI:  d.we = 1'b1;
      OP_LW: begin
        d.we  = 1'b1;
        d.src = SRC_MEM;
      end
      OP_JAL: begin
        d.we = 1'b1;
        d.rd = R_RA;
      end
      OP_SETX: begin
        d.we  = 1'b1;
        d.rd  = R_STATUS;
        d.src = SRC_SETX;
      end
      default: d.we = 1'b0;
    endcase
    if (d.rd == 5'd0) d.we = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/wb_retire_arbiter_md_result_fifo.sv
// In-order queue of late multdiv results ({rd, result}) with a registered one-hot
// mask of destination registers that are still waiting to retire.
module wb_retire_arbiter_md_result_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        ready,
  output logic        empty,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data,
  output logic [31:0] pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] head, tail, head_next;
  logic [CW-1:0] count, count_next;
  logic          push_en, pop_en;
  logic [31:0]   mask_next;
  logic [4:0]    slot_rd;
  logic [AW-1:0] offset;

  assign ready     = (count < CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_rd   = mem_rd[head];
  assign head_data = mem_data[head];

  // An rd of zero is acknowledged but never stored.
  assign push_en    = push && ready && (push_rd != 5'd0);
  assign pop_en     = pop && !empty;
  assign head_next  = head + AW'(pop_en);
  assign count_next = count + CW'(push_en) - CW'(pop_en);

  // Rebuild the mask from the post-update contents so duplicate rds stay exact.
  always_comb begin
    mask_next = '0;
    slot_rd   = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_rd = (push_en && (tail == AW'(i))) ? push_rd : mem_rd[i];
      offset  = AW'(i) - head_next;
      if ({1'b0, offset} < count_next) mask_next[slot_rd] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_rd[tail]   <= push_rd;
      mem_data[tail] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      pending_mask <= '0;
    end else begin
      head         <= head_next;
      tail         <= tail + AW'(push_en);
      count        <= count_next;
      pending_mask <= mask_next;
    end
  end

endmodule

// File: rtl/wb_retire_arbiter.sv
// Writeback stage: decodes the retiring MEM/WB instruction and shares the single
// regfile write port with queued multdiv results, stalling MEM/WB when the queue starves.
module wb_retire_arbiter
  import wb_retire_arbiter_pkg::*;
#(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mw_aluout,
  input  logic [31:0] mw_dataout,
  input  logic [31:0] mw_irout,
  input  logic        md_valid,
  input  logic [31:0] md_result,
  input  logic [4:0]  md_rd,
  output logic        md_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        wb_stall,
  output logic [31:0] pending_mask
);

  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  wb_dec_t       dec;
  logic [31:0]   pipe_data;
  logic          fifo_empty, fifo_pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic [SW-1:0] starve_cnt;
  logic          write_en;

  // md_valid/md_ready: a result transfers on a cycle where both are high; the
  // producer holds md_rd/md_result stable until then.
  wb_retire_arbiter_md_result_fifo #(
    .DEPTH(MD_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (md_valid),
    .push_rd      (md_rd),
    .push_data    (md_result),
    .pop          (fifo_pop),
    .ready        (md_ready),
    .empty        (fifo_empty),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .pending_mask (pending_mask)
  );

  always_comb begin
    dec = wb_decode(mw_irout);
    case (dec.src)
      SRC_MEM:  pipe_data = mw_dataout;
      SRC_SETX: pipe_data = {5'b0, mw_irout[26:0]};
      default:  pipe_data = mw_aluout;
    endcase
  end

  // A stall cycle belongs to the queue; otherwise the pipeline has priority.
  assign fifo_pop = !fifo_empty && (wb_stall || !dec.we);

  always_comb begin
    write_en      = 1'b0;
    ctrl_writeReg = '0;
    data_writeReg = '0;
    if (wb_stall) begin
      write_en      = !fifo_empty;
      ctrl_writeReg = head_rd;
      data_writeReg = head_data;
    end else if (dec.we) begin
      write_en      = 1'b1;
      ctrl_writeReg = dec.rd;
      data_writeReg = pipe_data;
    end else if (!fifo_empty) begin
      write_en      = 1'b1;
      ctrl_writeReg = head_rd;
      data_writeReg = head_data;
    end
  end

  assign ctrl_writeEnable = write_en && reset;

  // The stall cycle always pops, which clears the counter, so stalls never repeat back to back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else begin
      if (fifo_empty || fifo_pop) starve_cnt <= '0;
      else                        starve_cnt <= starve_cnt + SW'(1);
      wb_stall <= !fifo_empty && !fifo_pop && (starve_cnt == SW'(STARVE_LIMIT - 1));
    end
  end

endmodule

// File: tb/tb_wb_retire_arbiter.sv
// Directed bench for wb_retire_arbiter: a decode vector table plus hand-written
// multi-cycle sequences for the queue, starvation stall and mid-operation reset.
module tb_wb_retire_arbiter;

  localparam logic [4:0] T_RTYPE = 5'b00000;
  localparam logic [4:0] T_ADDI  = 5'b00101;
  localparam logic [4:0] T_LW    = 5'b01000;
  localparam logic [4:0] T_JAL   = 5'b00011;
  localparam logic [4:0] T_SETX  = 5'b10101;
  localparam logic [4:0] T_SW    = 5'b00111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mw_aluout = '0, mw_dataout = '0, mw_irout = '0;
  logic        md_valid = 1'b0;
  logic [31:0] md_result = '0;
  logic [4:0]  md_rd = '0;
  logic        md_ready, ctrl_writeEnable, wb_stall;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg, pending_mask;
  logic [4:0]  stim_rd = '0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  wb_retire_arbiter #(.MD_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .mw_aluout        (mw_aluout),
    .mw_dataout       (mw_dataout),
    .mw_irout         (mw_irout),
    .md_valid         (md_valid),
    .md_result        (md_result),
    .md_rd            (md_rd),
    .md_ready         (md_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wb_stall         (wb_stall),
    .pending_mask     (pending_mask)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] dat;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] aluop);
    return {op, rd, 15'b0, aluop, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // wr_rd is the register the presented instruction writes (0 if none).
  task automatic drive(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] dat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
                       input logic [4:0] wr_rd);
    mw_irout   = ir;
    mw_aluout  = alu;
    mw_dataout = dat;
    md_valid   = mv;
    md_rd      = mrd;
    md_result  = mres;
    stim_rd    = wr_rd;
  endtask

  // Checks the current cycle at the falling edge, then moves just past the next rising edge.
  task automatic expect_cyc(input string tag, input logic we, input logic [4:0] rg,
                            input logic [31:0] wd, input logic rdy, input logic stl,
                            input logic [31:0] mask);
    @(negedge clock);
    chk({tag, ".we"}, 32'(ctrl_writeEnable), 32'(we));
    if (we) begin
      chk({tag, ".reg"}, 32'(ctrl_writeReg), 32'(rg));
      chk({tag, ".data"}, data_writeReg, wd);
    end
    chk({tag, ".ready"}, 32'(md_ready), 32'(rdy));
    chk({tag, ".stall"}, 32'(wb_stall), 32'(stl));
    chk({tag, ".mask"}, pending_mask, mask);
    if (stim_rd != 5'd0) chk({tag, ".order"}, 32'(pending_mask[stim_rd]), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic sw_idle();
    drive(ins(T_SW, 5'd4, 5'd0), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
  endtask

  initial begin
    vecs[0]  = '{ins(T_ADDI, 5'd5, 5'd0),      32'h1234, 32'h0,        1'b1, 5'd5,  32'h1234};
    vecs[1]  = '{ins(T_LW, 5'd7, 5'd0),        32'h10,   32'hDEADBEEF, 1'b1, 5'd7,  32'hDEADBEEF};
    vecs[2]  = '{ins(T_JAL, 5'd3, 5'd0),       32'h55,   32'h0,        1'b1, 5'd31, 32'h55};
    vecs[3]  = '{{T_SETX, 27'h5},              32'h99,   32'h77,       1'b1, 5'd30, 32'h5};
    vecs[4]  = '{ins(T_RTYPE, 5'd0, 5'd0),     32'h11,   32'h0,        1'b0, 5'd0,  32'h0};
    vecs[5]  = '{ins(T_RTYPE, 5'd8, 5'b00001), 32'hAA,   32'hBB,       1'b1, 5'd8,  32'hAA};
    vecs[6]  = '{ins(T_RTYPE, 5'd8, 5'b00110), 32'hAA,   32'h0,        1'b0, 5'd0,  32'h0};
    vecs[7]  = '{ins(T_RTYPE, 5'd8, 5'b00111), 32'hAA,   32'h0,        1'b0, 5'd0,  32'h0};
    vecs[8]  = '{ins(T_SW, 5'd4, 5'd0),        32'h40,   32'h0,        1'b0, 5'd0,  32'h0};
    vecs[9]  = '{ins(T_ADDI, 5'd0, 5'd0),      32'h66,   32'h0,        1'b0, 5'd0,  32'h0};
    vecs[10] = '{ins(T_LW, 5'd0, 5'd0),        32'h0,    32'h12,       1'b0, 5'd0,  32'h0};

    // Reset state, with a writing instruction presented while reset is low.
    drive(ins(T_ADDI, 5'd5, 5'd0), 32'h1234, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    #2;
    chk("rst.we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst.ready", 32'(md_ready), 32'd1);
    chk("rst.stall", 32'(wb_stall), 32'd0);
    chk("rst.mask", pending_mask, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

    // Decode table, queue empty throughout.
    foreach (vecs[i]) begin
      drive(vecs[i].ir, vecs[i].alu, vecs[i].dat, 1'b0, 5'd0, 32'h0, vecs[i].we ? vecs[i].rg : 5'd0);
      expect_cyc($sformatf("vec%0d", i), vecs[i].we, vecs[i].rg, vecs[i].wd, 1'b1, 1'b0, 32'h0);
    end

    // Single multdiv result drains in the next idle slot.
    drive(ins(T_SW, 5'd4, 5'd0), 32'h0, 32'h0, 1'b1, 5'd9, 32'd42, 5'd0);
    expect_cyc("md1.push", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    sw_idle();
    expect_cyc("md1.ret", 1'b1, 5'd9, 32'd42, 1'b1, 1'b0, 32'h200);
    sw_idle();
    expect_cyc("md1.done", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Two results starved by continuous addi writes; each drains through one stall.
    drive(ins(T_ADDI, 5'd10, 5'd0), 32'd100, 32'h0, 1'b1, 5'd3, 32'h33, 5'd10);
    expect_cyc("st.t0", 1'b1, 5'd10, 32'd100, 1'b1, 1'b0, 32'h0);
    drive(ins(T_ADDI, 5'd11, 5'd0), 32'd101, 32'h0, 1'b1, 5'd4, 32'h44, 5'd11);
    expect_cyc("st.t1", 1'b1, 5'd11, 32'd101, 1'b1, 1'b0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      drive(ins(T_ADDI, 5'(12 + k), 5'd0), 32'(102 + k), 32'h0, 1'b0, 5'd0, 32'h0, 5'(12 + k));
      expect_cyc($sformatf("st.t%0d", 2 + k), 1'b1, 5'(12 + k), 32'(102 + k), 1'b0, 1'b0, 32'h18);
    end
    drive(ins(T_ADDI, 5'd15, 5'd0), 32'd105, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    expect_cyc("st.stall1", 1'b1, 5'd3, 32'h33, 1'b0, 1'b1, 32'h18);
    drive(ins(T_ADDI, 5'd15, 5'd0), 32'd105, 32'h0, 1'b0, 5'd0, 32'h0, 5'd15);
    expect_cyc("st.held1", 1'b1, 5'd15, 32'd105, 1'b1, 1'b0, 32'h10);
    for (int k = 0; k < 3; k++) begin
      drive(ins(T_ADDI, 5'(16 + k), 5'd0), 32'(106 + k), 32'h0, 1'b0, 5'd0, 32'h0, 5'(16 + k));
      expect_cyc($sformatf("st.t%0d", 7 + k), 1'b1, 5'(16 + k), 32'(106 + k), 1'b1, 1'b0, 32'h10);
    end
    drive(ins(T_ADDI, 5'd19, 5'd0), 32'd109, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    expect_cyc("st.stall2", 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 32'h10);
    drive(ins(T_ADDI, 5'd19, 5'd0), 32'd109, 32'h0, 1'b0, 5'd0, 32'h0, 5'd19);
    expect_cyc("st.held2", 1'b1, 5'd19, 32'd109, 1'b1, 1'b0, 32'h0);

    // Full queue: a push offered while popping is refused, then accepted once ready.
    drive(ins(T_ADDI, 5'd10, 5'd0), 32'd200, 32'h0, 1'b1, 5'd20, 32'hA, 5'd10);
    expect_cyc("full.u0", 1'b1, 5'd10, 32'd200, 1'b1, 1'b0, 32'h0);
    drive(ins(T_ADDI, 5'd11, 5'd0), 32'd201, 32'h0, 1'b1, 5'd21, 32'hB, 5'd11);
    expect_cyc("full.u1", 1'b1, 5'd11, 32'd201, 1'b1, 1'b0, 32'h0010_0000);
    drive(ins(T_SW, 5'd4, 5'd0), 32'h0, 32'h0, 1'b1, 5'd22, 32'hC, 5'd0);
    expect_cyc("full.u2", 1'b1, 5'd20, 32'hA, 1'b0, 1'b0, 32'h0030_0000);
    expect_cyc("full.u3", 1'b1, 5'd21, 32'hB, 1'b1, 1'b0, 32'h0020_0000);
    sw_idle();
    expect_cyc("full.u4", 1'b1, 5'd22, 32'hC, 1'b1, 1'b0, 32'h0040_0000);
    drive(ins(T_SW, 5'd4, 5'd0), 32'h0, 32'h0, 1'b1, 5'd0, 32'hF, 5'd0);
    expect_cyc("r0.push", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    sw_idle();
    expect_cyc("r0.after", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Reset asserted in the stall cycle with two entries queued.
    drive(ins(T_ADDI, 5'd10, 5'd0), 32'd300, 32'h0, 1'b1, 5'd3, 32'h33, 5'd10);
    expect_cyc("rr.v0", 1'b1, 5'd10, 32'd300, 1'b1, 1'b0, 32'h0);
    drive(ins(T_ADDI, 5'd11, 5'd0), 32'd301, 32'h0, 1'b1, 5'd4, 32'h44, 5'd11);
    expect_cyc("rr.v1", 1'b1, 5'd11, 32'd301, 1'b1, 1'b0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      drive(ins(T_ADDI, 5'(12 + k), 5'd0), 32'(302 + k), 32'h0, 1'b0, 5'd0, 32'h0, 5'(12 + k));
      expect_cyc($sformatf("rr.v%0d", 2 + k), 1'b1, 5'(12 + k), 32'(302 + k), 1'b0, 1'b0, 32'h18);
    end
    drive(ins(T_ADDI, 5'd15, 5'd0), 32'd305, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    @(negedge clock);
    chk("rr.stall_before", 32'(wb_stall), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rr.mask", pending_mask, 32'h0);
    chk("rr.stall", 32'(wb_stall), 32'd0);
    chk("rr.we", 32'(ctrl_writeEnable), 32'd0);
    chk("rr.ready", 32'(md_ready), 32'd1);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    drive(ins(T_ADDI, 5'd5, 5'd0), 32'h5A5A, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5);
    expect_cyc("rr.post", 1'b1, 5'd5, 32'h5A5A, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      sw_idle();
      expect_cyc($sformatf("rr.idle%0d", k), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
